// File: rtl/mem_access_ctrl.sv
// Async SRAM access sequencer: IDLE/SETUP/ACCESS/HOLD/DONE with WAIT_STATES strobe cycles.
// Optional per-byte lane selects via `define MEMCTL_BYTE_EN (adds ByteSel).
`timescale 1ns/1ps
module mem_access_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
`ifdef MEMCTL_BYTE_EN
    input  logic [1:0]  ByteSel,
`endif
    output logic [15:0] RData,
    output logic        Ack,
    output logic        Busy,
    output logic [15:0] Mem_A,
    input  logic [15:0] Mem_DQ_in,
    output logic [15:0] Mem_DQ_out,
    output logic        Mem_DQ_oe,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, HOLD, DONE
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_STATES - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [1:0]  be_q;
    logic        accept;
    logic        active;
    logic        last_acc;

    assign accept   = (state == IDLE) && Req;
    assign active   = (state == SETUP) || (state == ACCESS) || (state == HOLD);
    assign last_acc = (state == ACCESS) && (cnt == 3'd0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE:   if (Req) state_nx = SETUP;
            SETUP: begin
                state_nx = ACCESS;
                cnt_nx   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt == 3'd0) state_nx = HOLD;
                else             cnt_nx   = cnt - 3'd1;
            end
            HOLD:   state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= Wr;
            addr_q  <= Addr;
            wdata_q <= WData;
        end
    end

`ifdef MEMCTL_BYTE_EN
    // An empty lane select means a full-word access
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)      be_q <= 2'b11;
        else if (accept) be_q <= (ByteSel == 2'b00) ? 2'b11 : ByteSel;
    end

    assign Mem_UB = Mem_CE | ~be_q[1];
    assign Mem_LB = Mem_CE | ~be_q[0];
`else
    assign be_q   = 2'b11;
    assign Mem_UB = Mem_CE;
    assign Mem_LB = Mem_CE;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            rdata_q <= '0;
        else if (last_acc && !wr_q)
            rdata_q <= Mem_DQ_in & {{8{be_q[1]}}, {8{be_q[0]}}};
    end

    assign RData      = rdata_q;
    assign Ack        = (state == DONE);
    assign Busy       = (state != IDLE);
    assign Mem_A      = addr_q;
    assign Mem_CE     = ~active;
    assign Mem_OE     = ~((state == ACCESS) && !wr_q);
    assign Mem_WE     = ~((state == ACCESS) && wr_q);
    assign Mem_DQ_oe  = active && wr_q;
    assign Mem_DQ_out = Mem_DQ_oe ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses, held Req, reset abort,
// and WAIT_STATES=1/7 instances; byte-lane cases when MEMCTL_BYTE_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] Addr = '0;
    logic [15:0] WData = '0;
`ifdef MEMCTL_BYTE_EN
    logic [1:0]  ByteSel = 2'b11;
`endif

    logic [15:0] RData, Mem_A, dq_in, Mem_DQ_out;
    logic        Ack, Busy, Mem_DQ_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    logic        r1 = 1'b0, r7 = 1'b0;
    logic [15:0] rd1, ma1, dqo1, rd7, ma7, dqo7;
    logic        ack1, bsy1, doe1, ce1, ub1, lb1, oe1, we1;
    logic        ack7, bsy7, doe7, ce7, ub7, lb7, oe7, we7;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    mem_access_ctrl #(.WAIT_STATES(W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr),
        .Addr(Addr), .WData(WData),
`ifdef MEMCTL_BYTE_EN
        .ByteSel(ByteSel),
`endif
        .RData(RData), .Ack(Ack), .Busy(Busy), .Mem_A(Mem_A),
        .Mem_DQ_in(dq_in), .Mem_DQ_out(Mem_DQ_out), .Mem_DQ_oe(Mem_DQ_oe),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    mem_access_ctrl #(.WAIT_STATES(1)) u_w1 (
        .Clk(Clk), .Reset(Reset), .Req(r1), .Wr(1'b0),
        .Addr(Addr), .WData(WData),
`ifdef MEMCTL_BYTE_EN
        .ByteSel(2'b11),
`endif
        .RData(rd1), .Ack(ack1), .Busy(bsy1), .Mem_A(ma1),
        .Mem_DQ_in(16'hC0DE), .Mem_DQ_out(dqo1), .Mem_DQ_oe(doe1),
        .Mem_CE(ce1), .Mem_UB(ub1), .Mem_LB(lb1),
        .Mem_OE(oe1), .Mem_WE(we1)
    );

    mem_access_ctrl #(.WAIT_STATES(7)) u_w7 (
        .Clk(Clk), .Reset(Reset), .Req(r7), .Wr(1'b0),
        .Addr(Addr), .WData(WData),
`ifdef MEMCTL_BYTE_EN
        .ByteSel(2'b11),
`endif
        .RData(rd7), .Ack(ack7), .Busy(bsy7), .Mem_A(ma7),
        .Mem_DQ_in(16'hC0DE), .Mem_DQ_out(dqo7), .Mem_DQ_oe(doe7),
        .Mem_CE(ce7), .Mem_UB(ub7), .Mem_LB(lb7),
        .Mem_OE(oe7), .Mem_WE(we7)
    );

    // SRAM model with a preload port used while the DUT is in reset
    logic [15:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_a = '0;
    logic [15:0] ld_d = '0;

    assign dq_in = mem[Mem_A[7:0]];

    always @(posedge Clk) begin
        if (ld_en) begin
            mem[ld_a] <= ld_d;
        end else if (!Mem_CE && !Mem_WE) begin
            if (!Mem_UB) mem[Mem_A[7:0]][15:8] <= Mem_DQ_out[15:8];
            if (!Mem_LB) mem[Mem_A[7:0]][7:0]  <= Mem_DQ_out[7:0];
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [1:0]  ubl;
        int          k;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: per-cycle strobe protocol, per-response checks at Ack
    int   n_oe = 0, n_we = 0, n_dq = 0;
    logic proto_bad = 1'b0;

    always @(negedge Clk) begin
        if (!Reset) begin
            n_oe = 0; n_we = 0; n_dq = 0;
            proto_bad = 1'b0;
        end else begin
            if (!Mem_OE) n_oe++;
            if (!Mem_WE) n_we++;
            if (Mem_DQ_oe) n_dq++;
            if (!Mem_OE && !Mem_WE) proto_bad = 1'b1;
            if (!Mem_WE && !Mem_DQ_oe) proto_bad = 1'b1;
            if (Busy !== (!Mem_CE || Ack)) proto_bad = 1'b1;
            if (!Mem_CE) begin
                if (q.size() == 0) begin
                    proto_bad = 1'b1;
                end else begin
                    if (Mem_A !== q[0].addr) proto_bad = 1'b1;
                    if ({Mem_UB, Mem_LB} !== q[0].ubl) proto_bad = 1'b1;
                    if (Mem_DQ_oe && Mem_DQ_out !== q[0].wdata)
                        proto_bad = 1'b1;
                end
            end else if ({Mem_UB, Mem_LB} !== 2'b11 || !Mem_OE ||
                         !Mem_WE || Mem_DQ_oe) begin
                proto_bad = 1'b1;
            end
            if (Ack) begin
                chk("ack_pending", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", 32'(RData), 32'(e.rdata));
                    chk("ack_lat", cyc - e.k, W + 2);
                    chk("oe_width", n_oe, e.wr ? 0 : W);
                    chk("we_width", n_we, e.wr ? W : 0);
                    chk("dq_oe_width", n_dq, e.wr ? W + 2 : 0);
                    chk("protocol", 32'(proto_bad), 0);
                end
                n_oe = 0; n_we = 0; n_dq = 0;
                proto_bad = 1'b0;
            end
        end
    end

    function automatic logic [1:0] ubl_of(input logic [1:0] bs);
`ifdef MEMCTL_BYTE_EN
        return (bs == 2'b00) ? 2'b00 : ~bs;
`else
        return (bs == 2'b00) ? 2'b00 : 2'b00;
`endif
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge Clk);
        chk("sb_drain", q.size(), 0);
        q.delete();
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clk);
        ld_en = 1'b1; ld_a = a; ld_d = d;
    endtask

    // One-cycle Req pulse; inputs are scrambled right after acceptance
    task automatic issue(input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rd,
                         input logic [1:0] bs);
        exp_t e;
        wait_idle();
        @(negedge Clk);
        Req = 1'b1; Wr = wr; Addr = a; WData = d;
`ifdef MEMCTL_BYTE_EN
        ByteSel = bs;
`endif
        e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd;
        e.ubl = ubl_of(bs); e.k = cyc + 1;
        q.push_back(e);
        @(negedge Clk);
        Req = 1'b0; Wr = ~wr;
        Addr = 16'($urandom); WData = 16'($urandom);
`ifdef MEMCTL_BYTE_EN
        ByteSel = 2'($urandom);
`endif
    endtask

    // Req held high, Addr stepping every cycle: accepts every W+4 edges
    task automatic stream(input int n);
        exp_t e;
        wait_idle();
        @(negedge Clk);
`ifdef MEMCTL_BYTE_EN
        ByteSel = 2'b11;
`endif
        for (int c = 0; c < n * (W + 4); c++) begin
            if (c > 0) @(negedge Clk);
            Req = 1'b1; Wr = 1'b0;
            Addr = 16'h0040 + 16'(c); WData = 16'($urandom);
            if (c % (W + 4) == 0) begin
                e.wr = 1'b0; e.addr = Addr; e.wdata = '0;
                e.rdata = 16'hA000 | Addr; e.ubl = 2'b00; e.k = cyc + 1;
                q.push_back(e);
            end
        end
        @(negedge Clk);
        Req = 1'b0;
    endtask

    task automatic reset_abort();
        wait_idle();
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Addr = 16'h0022; WData = 16'h5555;
`ifdef MEMCTL_BYTE_EN
        ByteSel = 2'b11;
`endif
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}),
            32'h1f);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_ack", 32'(Ack), 0);
        chk("abort_dq_oe", 32'(Mem_DQ_oe), 0);
        chk("abort_rdata", 32'(RData), 0);
        @(negedge Clk);
        chk("abort_ack_hold", 32'(Ack), 0);
        Reset = 1'b1;
    endtask

    task automatic aux(input int sel);
        int k, lat, n;
        logic [15:0] rd;
        lat = -1; n = 0; rd = '0;
        @(negedge Clk);
        if (sel == 1) r1 = 1'b1;
        else          r7 = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            r1 = 1'b0; r7 = 1'b0;
            if (sel == 1 ? !oe1 : !oe7) n++;
            if ((sel == 1 ? ack1 : ack7) && lat < 0) begin
                lat = cyc - k;
                rd = (sel == 1) ? rd1 : rd7;
            end
        end
        chk(sel == 1 ? "w1_strobe" : "w7_strobe", n, sel);
        chk(sel == 1 ? "w1_lat" : "w7_lat", lat, sel + 2);
        chk(sel == 1 ? "w1_rdata" : "w7_rdata", 32'(rd), 32'hC0DE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load(8'h10, 16'hBEEF);
        load(8'h30, 16'hBEEF);
        for (int a = 'h40; a < 'h60; a++) load(8'(a), 16'hA000 | 16'(a));
        @(negedge Clk);
        ld_en = 1'b0;
        #1;
        chk("rst_rdata", 32'(RData), 0);
        chk("rst_ack", 32'(Ack), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_mem_a", 32'(Mem_A), 0);
        chk("rst_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}),
            32'h1f);
        chk("rst_dq_oe", 32'(Mem_DQ_oe), 0);
        chk("rst_dq_out", 32'(Mem_DQ_out), 0);
        @(negedge Clk);
        Reset = 1'b1;

        issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2'b11);
        issue(1'b1, 16'h0020, 16'h1234, 16'hBEEF, 2'b11);
        issue(1'b0, 16'h0020, 16'h0000, 16'h1234, 2'b11);
        issue(1'b1, 16'h0021, 16'hFFFF, 16'h1234, 2'b11);
        issue(1'b0, 16'h0021, 16'h0000, 16'hFFFF, 2'b11);
        issue(1'b1, 16'h0010, 16'h0000, 16'hFFFF, 2'b11);
        issue(1'b0, 16'h0010, 16'h0000, 16'h0000, 2'b11);

        stream(3);

        reset_abort();
        issue(1'b0, 16'h0020, 16'h0000, 16'h1234, 2'b11);

`ifdef MEMCTL_BYTE_EN
        issue(1'b0, 16'h0030, 16'h0000, 16'hBE00, 2'b10);
        issue(1'b0, 16'h0030, 16'h0000, 16'hBEEF, 2'b00);
        issue(1'b0, 16'h0030, 16'h0000, 16'h00EF, 2'b01);
`endif

        wait_idle();
        aux(1);
        aux(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
